// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: state encoding, selector map layout and the power-on route.
// Also consumed by the crossbar datapath, so keep field order stable.
package xbar_pkg;

  localparam int XBAR_PORTS = 4;
  localparam int SEL_W      = 2;
  localparam int MAP_W      = XBAR_PORTS * SEL_W;
  localparam int CNT_W      = 4;

  // Packed {d,c,b,a}: a=3, b=2, c=0, d=1
  localparam logic [MAP_W-1:0] RESET_MAP_DEF = 8'b01_00_10_11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    BLANK   = 2'd2
  } state_t;

  typedef struct packed {
    logic [SEL_W-1:0] d;
    logic [SEL_W-1:0] c;
    logic [SEL_W-1:0] b;
    logic [SEL_W-1:0] a;
  } sel_map_t;

endpackage

// File: rtl/xbar_perm_check.sv
// Flags whether four 2-bit selectors form a permutation (all pairwise distinct).
// Purely combinational, zero latency; no flow control.
module xbar_perm_check
  import xbar_pkg::*;
(
  input  logic [SEL_W-1:0] sel_a,
  input  logic [SEL_W-1:0] sel_b,
  input  logic [SEL_W-1:0] sel_c,
  input  logic [SEL_W-1:0] sel_d,
  output logic             is_perm
);

  // With four outputs and four sources, pairwise-distinct is exactly a permutation.
  assign is_perm = (sel_a != sel_b) && (sel_a != sel_c) && (sel_a != sel_d) &&
                   (sel_b != sel_c) && (sel_b != sel_d) && (sel_c != sel_d);

endmodule

// File: rtl/xbar_route_ctl.sv
// Accepts crossbar routing maps, holds them in a shadow and commits at frame_sync under a blank strobe.
// Latency: commit on edge after frame_sync, blank BLANK_CYCLES+1 cycles; cfg_ready low outside IDLE.
module xbar_route_ctl
  import xbar_pkg::*;
#(
  parameter logic [MAP_W-1:0] RESET_MAP    = RESET_MAP_DEF,
  parameter int unsigned      BLANK_CYCLES = 2,
  parameter bit               REQUIRE_PERM = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst_in_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SEL_W-1:0] cfg_sel_a,
  input  logic [SEL_W-1:0] cfg_sel_b,
  input  logic [SEL_W-1:0] cfg_sel_c,
  input  logic [SEL_W-1:0] cfg_sel_d,
  input  logic             frame_sync,
  output logic [SEL_W-1:0] xbar_selectors_a,
  output logic [SEL_W-1:0] xbar_selectors_b,
  output logic [SEL_W-1:0] xbar_selectors_c,
  output logic [SEL_W-1:0] xbar_selectors_d,
  output logic             xbar_blank,
  output logic             cfg_err,
  output logic             cfg_done,
  output logic             pending
);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES);

  state_t             state_q, state_d;
  sel_map_t           sel_q, sel_d;
  sel_map_t           shadow_q, shadow_d;
  sel_map_t           cfg_map;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               blank_q, blank_d;
  logic               pending_q, pending_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               perm_ok;

  assign cfg_map = '{d: cfg_sel_d, c: cfg_sel_c, b: cfg_sel_b, a: cfg_sel_a};

  generate
    if (REQUIRE_PERM) begin : g_perm
      xbar_perm_check u_perm_check (
        .sel_a   (cfg_sel_a),
        .sel_b   (cfg_sel_b),
        .sel_c   (cfg_sel_c),
        .sel_d   (cfg_sel_d),
        .is_perm (perm_ok)
      );
    end else begin : g_any_map
      assign perm_ok = 1'b1;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    shadow_d  = shadow_q;
    cnt_d     = cnt_q;
    blank_d   = blank_q;
    pending_d = pending_q;
    err_d     = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (perm_ok) begin
            shadow_d  = cfg_map;
            pending_d = 1'b1;
            state_d   = PENDING;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PENDING: begin
        if (frame_sync) begin
          state_d   = BLANK;
          blank_d   = 1'b1;
          pending_d = 1'b0;
          cnt_d     = '0;
        end
      end
      BLANK: begin
        cnt_d = cnt_q + 1'b1;
        // Selectors switch one edge after blank rises so mute is already in effect.
        if (cnt_q == '0) begin
          sel_d = shadow_q;
        end
        if (cnt_q == BLANK_LAST) begin
          blank_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q   <= IDLE;
      sel_q     <= sel_map_t'(RESET_MAP);
      shadow_q  <= '0;
      cnt_q     <= '0;
      blank_q   <= 1'b0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      blank_q   <= blank_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign cfg_ready        = (state_q == IDLE);
  assign xbar_selectors_a = sel_q.a;
  assign xbar_selectors_b = sel_q.b;
  assign xbar_selectors_c = sel_q.c;
  assign xbar_selectors_d = sel_q.d;
  assign xbar_blank       = blank_q;
  assign cfg_err          = err_q;
  assign cfg_done         = done_q;
  assign pending          = pending_q;

endmodule

// File: tb/tb_xbar_route_ctl.sv
// Directed bench for xbar_route_ctl: instance 0 default, 1 without perm check,
// 2 with BLANK_CYCLES=1, 3 with BLANK_CYCLES=15; stimulus shared except cfg_valid.
module tb_xbar_route_ctl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_sync = 1'b0;
  logic [1:0] sel_a = '0, sel_b = '0, sel_c = '0, sel_d = '0;
  logic       valid [4];
  logic       rdy [4];
  logic       blank [4];
  logic       err [4];
  logic       done [4];
  logic       pend [4];
  logic [1:0] sa [4];
  logic [1:0] sb [4];
  logic [1:0] sc [4];
  logic [1:0] sd [4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      xbar_route_ctl #(
        .BLANK_CYCLES ((g == 2) ? 1 : (g == 3) ? 15 : 2),
        .REQUIRE_PERM ((g == 1) ? 1'b0 : 1'b1)
      ) dut (
        .clk_in           (clk),
        .rst_in_n         (rst_n),
        .cfg_valid        (valid[g]),
        .cfg_ready        (rdy[g]),
        .cfg_sel_a        (sel_a),
        .cfg_sel_b        (sel_b),
        .cfg_sel_c        (sel_c),
        .cfg_sel_d        (sel_d),
        .frame_sync       (frame_sync),
        .xbar_selectors_a (sa[g]),
        .xbar_selectors_b (sb[g]),
        .xbar_selectors_c (sc[g]),
        .xbar_selectors_d (sd[g]),
        .xbar_blank       (blank[g]),
        .cfg_err          (err[g]),
        .cfg_done         (done[g]),
        .pending          (pend[g])
      );
    end
  endgenerate

  function automatic logic [7:0] map_of(input int i);
    return {sd[i], sc[i], sb[i], sa[i]};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_map(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                         input logic [1:0] d);
    sel_a = a; sel_b = b; sel_c = c; sel_d = d;
  endtask

  int bw [4];
  int dc [4];

  initial begin
    for (int i = 0; i < 4; i++) valid[i] = 1'b0;
    #22 rst_n = 1'b1;
    step();

    // Reset state
    check("rst_map",   {8'h0, map_of(0)}, 16'h004B);
    check("rst_blank", {15'h0, blank[0]}, 16'h0);
    check("rst_ready", {15'h0, rdy[0]},   16'h1);
    check("rst_pend",  {15'h0, pend[0]},  16'h0);
    check("rst_err",   {15'h0, err[0]},   16'h0);
    check("rst_done",  {15'h0, done[0]},  16'h0);

    // Normal commit: map 0/1/2/3, frame_sync five cycles later
    set_map(2'd0, 2'd1, 2'd2, 2'd3);
    valid[0] = 1'b1;
    step();
    valid[0] = 1'b0;
    check("acc_pend",  {15'h0, pend[0]}, 16'h1);
    check("acc_ready", {15'h0, rdy[0]},  16'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("wait_pend",  {15'h0, pend[0]},  16'h1);
      check("wait_blank", {15'h0, blank[0]}, 16'h0);
    end
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    check("e0_blank", {15'h0, blank[0]}, 16'h1);
    check("e0_pend",  {15'h0, pend[0]},  16'h0);
    check("e0_map",   {8'h0, map_of(0)}, 16'h004B);
    step();
    check("e1_blank", {15'h0, blank[0]}, 16'h1);
    check("e1_map",   {8'h0, map_of(0)}, 16'h00E4);
    step();
    check("e2_blank", {15'h0, blank[0]}, 16'h1);
    check("e2_done",  {15'h0, done[0]},  16'h0);
    step();
    check("e3_blank", {15'h0, blank[0]}, 16'h0);
    check("e3_done",  {15'h0, done[0]},  16'h1);
    check("e3_ready", {15'h0, rdy[0]},   16'h1);
    step();
    check("done_pulse", {15'h0, done[0]}, 16'h0);

    // Duplicate map 1/1/2/3: rejected by instance 0, accepted by instance 1
    set_map(2'd1, 2'd1, 2'd2, 2'd3);
    valid[0] = 1'b1;
    valid[1] = 1'b1;
    step();
    valid[0] = 1'b0;
    valid[1] = 1'b0;
    check("dup_err",    {15'h0, err[0]},  16'h1);
    check("dup_pend",   {15'h0, pend[0]}, 16'h0);
    check("dup_ready",  {15'h0, rdy[0]},  16'h1);
    check("np_pend",    {15'h0, pend[1]}, 16'h1);
    check("np_err",     {15'h0, err[1]},  16'h0);
    step();
    check("dup_err_clr", {15'h0, err[0]}, 16'h0);
    check("dup_map",     {8'h0, map_of(0)}, 16'h00E4);
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    check("np_blank",   {15'h0, blank[1]}, 16'h1);
    check("idle_fs_ign", {15'h0, blank[0]}, 16'h0);
    step();
    check("np_map",     {8'h0, map_of(1)}, 16'h00E5);
    step();
    step();
    check("np_done",    {15'h0, done[1]}, 16'h1);

    // Accept with frame_sync on the same edge, second offer while PENDING
    set_map(2'd2, 2'd3, 2'd0, 2'd1);
    valid[0] = 1'b1;
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    check("same_pend",  {15'h0, pend[0]},  16'h1);
    check("same_blank", {15'h0, blank[0]}, 16'h0);
    check("same_ready", {15'h0, rdy[0]},   16'h0);
    set_map(2'd3, 2'd3, 2'd1, 2'd2);
    step();
    valid[0] = 1'b0;
    check("pend2_err",   {15'h0, err[0]},  16'h0);
    check("pend2_ready", {15'h0, rdy[0]},  16'h0);
    check("pend2_pend",  {15'h0, pend[0]}, 16'h1);
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    check("late_blank", {15'h0, blank[0]}, 16'h1);
    step();
    check("late_map",   {8'h0, map_of(0)}, 16'h004E);
    step();
    step();
    check("late_done",  {15'h0, done[0]}, 16'h1);
    step();

    // Reset in the middle of BLANK
    set_map(2'd0, 2'd1, 2'd2, 2'd3);
    valid[0] = 1'b1;
    step();
    valid[0] = 1'b0;
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    step();
    check("mid_map_pre", {8'h0, map_of(0)}, 16'h00E4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_map",   {8'h0, map_of(0)}, 16'h004B);
    check("arst_blank", {15'h0, blank[0]}, 16'h0);
    #2 rst_n = 1'b1;
    dc[0] = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done[0]) dc[0]++;
    end
    check("arst_nodone", 16'(dc[0]), 16'h0);
    check("arst_ready",  {15'h0, rdy[0]}, 16'h1);
    check("arst_pend",   {15'h0, pend[0]}, 16'h0);

    // Identical-map commit with blank width sweep
    set_map(2'd3, 2'd2, 2'd0, 2'd1);
    valid[0] = 1'b1;
    valid[2] = 1'b1;
    valid[3] = 1'b1;
    step();
    valid[0] = 1'b0;
    valid[2] = 1'b0;
    valid[3] = 1'b0;
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    for (int j = 0; j < 4; j++) begin
      bw[j] = 0;
      dc[j] = 0;
    end
    for (int i = 0; i < 30; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (blank[j]) bw[j]++;
        if (done[j]) dc[j]++;
      end
      step();
    end
    check("same_w_b2",  16'(bw[0]), 16'd3);
    check("same_d_b2",  16'(dc[0]), 16'd1);
    check("width_b1",   16'(bw[2]), 16'd2);
    check("done_b1",    16'(dc[2]), 16'd1);
    check("width_b15",  16'(bw[3]), 16'd16);
    check("done_b15",   16'(dc[3]), 16'd1);
    check("same_map",   {8'h0, map_of(0)}, 16'h004B);
    check("b15_map",    {8'h0, map_of(3)}, 16'h004B);
    check("b15_ready",  {15'h0, rdy[3]},   16'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xbar_route_ctl.md
Name: xbar_route_ctl

Overview:
Mode-control stage directly upstream of the 4x4 crossbar output mux. It accepts new routing maps over a valid/ready handshake and rejects maps that are not permutations. Accepted maps are held in a shadow register and committed only at a frame boundary. During each commit it raises a registered blank strobe, so downstream channel logic can mute outputs and never see a half-switched route.

Parameters:
RESET_MAP, 8'b01_00_10_11, power-on selectors packed {d,c,b,a}: a=3, b=2, c=0, d=1
BLANK_CYCLES, 2, cycles blank stays high after the selector update edge; legal range 1..15
REQUIRE_PERM, 1, 1 = reject maps with duplicate sources; 0 = accept any map

Ports:
clk_in  in  1  system clock, all logic on rising edge
rst_in_n  in  1  asynchronous active-low reset
cfg_valid  in  1  new map offered
cfg_ready  out  1  block can accept a map
cfg_sel_a  in  2  requested source index for output a
cfg_sel_b  in  2  requested source index for output b
cfg_sel_c  in  2  requested source index for output c
cfg_sel_d  in  2  requested source index for output d
frame_sync  in  1  single-cycle frame-boundary pulse, synchronous to clk_in
xbar_selectors_a  out  2  registered selector to crossbar, output a
xbar_selectors_b  out  2  registered selector to crossbar, output b
xbar_selectors_c  out  2  registered selector to crossbar, output c
xbar_selectors_d  out  2  registered selector to crossbar, output d
xbar_blank  out  1  downstream mute strobe
cfg_err  out  1  one-cycle pulse: offered map rejected
cfg_done  out  1  one-cycle pulse: commit finished
pending  out  1  map accepted, waiting for frame_sync

Behaviour:
- Clock and reset: one clock, clk_in; reset rst_in_n is asynchronous, active-low.
- Reset values: state=IDLE; selectors=RESET_MAP; xbar_blank=0; cfg_err=0; cfg_done=0; pending=0; shadow cleared. cfg_ready=1 from the first edge after deassertion.
- All outputs are registered except cfg_ready, which is decoded combinationally from state (1 only in IDLE).
- States: IDLE, PENDING, BLANK.
- IDLE, handshake:
  - A transfer occurs when cfg_valid & cfg_ready are both high at a rising edge.
  - If REQUIRE_PERM=1 and any two cfg_sel values are equal: cfg_err=1 for the next cycle only, state stays IDLE, shadow unchanged.
  - Otherwise: latch shadow, go to PENDING, pending=1 next cycle.
- IDLE, other inputs: frame_sync is ignored.
- PENDING:
  - cfg_ready=0; cfg_valid is ignored and never errors.
  - A frame_sync on the same edge as the accepting transfer does not count; only frame_sync sampled while in PENDING counts.
  - On frame_sync (edge E0): state=BLANK, xbar_blank=1, pending=0, counter=0. Selectors are unchanged at E0.
- BLANK:
  - E1: selectors load the shadow, all four on the same edge.
  - Counter increments each edge.
  - Edge E(BLANK_CYCLES+1): xbar_blank=0, cfg_done=1 for one cycle, state=IDLE.
  - Net result: blank is high for BLANK_CYCLES+1 cycles and brackets the selector change by at least one cycle on each side.
- frame_sync while in BLANK: ignored.
- Reset mid-operation (any state): shadow discarded, selectors return to RESET_MAP immediately, blank drops asynchronously, no cfg_done.
- Counter width: 4 bits; no wrap-around is possible within the legal range.
- A map identical to the current selectors still executes the full blank sequence (no short-circuit).

Decomposition:
- Shared package (xbar_pkg): state encoding (IDLE=0, PENDING=1, BLANK=2); XBAR_PORTS=4; SEL_W=2; the RESET_MAP default constant. This package is also used by the crossbar itself.
- One natural sub-module: xbar_perm_check. It is combinational, takes the four 2-bit selectors, and outputs is_perm. Instantiate it only when REQUIRE_PERM=1.

Test Plan:
- Reset release -> selectors a/b/c/d = 3/2/0/1, xbar_blank=0, cfg_ready=1, pending=0.
- Offer map 0/1/2/3 at t, frame_sync at t+5 -> pending high t+1..t+5. Blank high for 3 cycles starting t+6. Selectors change to 0/1/2/3 at the second of those cycles. cfg_done pulses one cycle as blank falls.
- Offer duplicate map 1/1/2/3 with REQUIRE_PERM=1 -> cfg_err single pulse, pending stays 0, selectors unchanged. With REQUIRE_PERM=0 the same map is accepted.
- Accept a map, then offer a second map while PENDING and pulse frame_sync in the same cycle as the accept -> cfg_ready=0 during PENDING, second map ignored, first frame_sync ignored. Commit happens only on a later frame_sync.
- Assert rst_in_n low in the middle of BLANK -> selectors return to RESET_MAP and blank=0 without waiting for a clock edge. After release, no cfg_done and state is IDLE.
- Offer a map identical to the current selectors -> full blank sequence and cfg_done still occur. Sweep BLANK_CYCLES=1 and 15 and confirm blank widths of 2 and 16 cycles.
